// File: rtl/seg7_scan_driver.sv
// Purpose : 8-digit multiplexed 7-segment scanner for frequency (digits 7..4) and period (3..0) BCD words.
// Latency : an update shows from the first slot of the next frame; an update on the frame boundary shows in the frame starting then.
// Backpressure: none; i_update is always accepted and the newest pending word replaces any older one.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_update                  one-cycle strobe qualifying all data inputs
//   i_freq_bcd/point/k        frequency BCD word, decimal-point position, kHz flag
//   i_period_bcd/point/m      period BCD word, decimal-point position, ms flag
//   o_seg[7:0]                {dp, g..a} for the currently selected digit
//   o_dig_sel[7:0]            one-hot digit enable, bit 7 = leftmost digit
//   o_led_k, o_led_m          unit flags of the displayed (shadow) data
//   o_frame_done              one-cycle pulse in the first cycle of each frame
module seg7_scan_driver #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int SCAN_HZ        = 8000,
  parameter int GUARD_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_update,
  input  logic [15:0] i_freq_bcd,
  input  logic [2:0]  i_freq_point,
  input  logic        i_freq_k,
  input  logic [15:0] i_period_bcd,
  input  logic [2:0]  i_period_point,
  input  logic        i_period_m,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_dig_sel,
  output logic        o_led_k,
  output logic        o_led_m,
  output logic        o_frame_done
);

  localparam int SLOT  = CLOCK_FREQ / SCAN_HZ;
  localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
  // XOR mask: turns active-high seg/dig_sel into the pin polarity; also the "all off" value.
  localparam logic [7:0] OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef struct packed {
    logic [15:0] freq_bcd;
    logic [2:0]  freq_point;
    logic        freq_k;
    logic [15:0] period_bcd;
    logic [2:0]  period_point;
    logic        period_m;
  } disp_t;

  // Active-high a..g pattern; non-BCD nibbles show 'E'.
  function automatic logic [6:0] nib_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    nib_seg = 7'h3F;
      4'd1:    nib_seg = 7'h06;
      4'd2:    nib_seg = 7'h5B;
      4'd3:    nib_seg = 7'h4F;
      4'd4:    nib_seg = 7'h66;
      4'd5:    nib_seg = 7'h6D;
      4'd6:    nib_seg = 7'h7D;
      4'd7:    nib_seg = 7'h07;
      4'd8:    nib_seg = 7'h7F;
      4'd9:    nib_seg = 7'h6F;
      default: nib_seg = 7'h79;
    endcase
  endfunction

  // Active-high {dp, g..a} for digit n (0 = rightmost) of a 4-digit group.
  function automatic logic [7:0] digit_seg(input logic [15:0] bcd,
                                           input logic [2:0]  point,
                                           input logic [1:0]  n);
    logic [3:0] nib;
    logic       p_ok;
    logic       dp;
    logic       lz;
    logic       blank;
    nib  = 4'(bcd >> {n, 2'b00});
    p_ok = (point != 3'd0) && (point < 3'd4);
    dp   = p_ok && ({1'b0, n} == point);
    // lz: this digit and every digit to its left are zero
    lz   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(n)) && (bcd[4*k +: 4] != 4'd0)) lz = 1'b0;
    end
    // Digits at or right of the decimal point stay lit so "0.05"-style values read correctly.
    blank = lz && (n != 2'd0) && !(p_ok && ({1'b0, n} <= point));
    digit_seg = blank ? 8'h00 : {dp, nib_seg(nib)};
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  disp_t            r_pend_dat;
  logic             r_pend_vld;
  disp_t            r_shadow;
  logic [7:0]       r_seg;
  logic [7:0]       r_dig_sel;
  logic             r_led_k;
  logic             r_led_m;
  logic             r_frame_done;

  disp_t            w_in;
  disp_t            w_shadow_nxt;
  logic             w_wrap;
  logic             w_frame;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [15:0]      w_grp_bcd;
  logic [2:0]       w_grp_point;
  logic [7:0]       w_seg_hi;

  assign w_in = {i_freq_bcd, i_freq_point, i_freq_k, i_period_bcd, i_period_point, i_period_m};

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign w_frame   = w_wrap && (r_idx == 3'd0);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
  // 0 - 1 wraps to 7, giving the 7..0 scan order for free
  assign w_idx_nxt = w_wrap ? r_idx - 3'd1 : r_idx;

  // Shadow changes only on the frame boundary; a coincident update bypasses pending.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_frame) begin
      if (i_update)        w_shadow_nxt = w_in;
      else if (r_pend_vld) w_shadow_nxt = r_pend_dat;
    end
  end

  // Outputs are decoded from next-state values so the registered pins line up with r_cnt/r_idx.
  assign w_grp_bcd   = w_idx_nxt[2] ? w_shadow_nxt.freq_bcd   : w_shadow_nxt.period_bcd;
  assign w_grp_point = w_idx_nxt[2] ? w_shadow_nxt.freq_point : w_shadow_nxt.period_point;
  assign w_seg_hi    = digit_seg(w_grp_bcd, w_grp_point, w_idx_nxt[1:0]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= 3'd7;
      r_pend_dat   <= '0;
      r_pend_vld   <= 1'b0;
      r_shadow     <= '0;
      r_seg        <= OFF;
      r_dig_sel    <= OFF;
      r_led_k      <= 1'b0;
      r_led_m      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      if (i_update && !w_frame) begin
        r_pend_dat <= w_in;
        r_pend_vld <= 1'b1;
      end else if (w_frame) begin
        r_pend_vld <= 1'b0;
      end
      r_frame_done <= w_frame;
      r_led_k      <= r_shadow.freq_k;
      r_led_m      <= r_shadow.period_m;
      // Guard cycles deselect every digit so the previous digit's segments cannot ghost.
      r_dig_sel    <= (w_cnt_nxt < CNT_GUARD) ? OFF : (OFF ^ (8'd1 << w_idx_nxt));
      r_seg        <= OFF ^ w_seg_hi;
    end
  end

  assign o_seg        = r_seg;
  assign o_dig_sel    = r_dig_sel;
  assign o_led_k      = r_led_k;
  assign o_led_m      = r_led_m;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver (SLOT=8, GUARD=2, active-low pins).
// Stimulus pushes the expected frame image into a queue; a negedge monitor rebuilds each
// displayed frame from dig_sel/seg and compares it when frame_done closes the frame.
module tb_seg7_scan_driver;

  localparam int SLOT_C  = 8;
  localparam int GUARD_C = 2;
  localparam logic [63:0] RST_PAT = 64'hFFFFFFC0_FFFFFFC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0;
  logic [15:0] freq_bcd = '0;
  logic [2:0]  freq_point = '0;
  logic        freq_k = 1'b0;
  logic [15:0] period_bcd = '0;
  logic [2:0]  period_point = '0;
  logic        period_m = 1'b0;
  logic [7:0]  seg;
  logic [7:0]  dig_sel;
  logic        led_k;
  logic        led_m;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLOCK_FREQ(80),
    .SCAN_HZ(10),
    .GUARD_CYCLES(GUARD_C),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_update(update),
    .i_freq_bcd(freq_bcd),
    .i_freq_point(freq_point),
    .i_freq_k(freq_k),
    .i_period_bcd(period_bcd),
    .i_period_point(period_point),
    .i_period_m(period_m),
    .o_seg(seg),
    .o_dig_sel(dig_sel),
    .o_led_k(led_k),
    .o_led_m(led_m),
    .o_frame_done(frame_done)
  );

  typedef struct {
    int          frame;
    logic [63:0] segs;   // {digit7 .. digit0}, active-low
    logic        k;
    logic        m;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int frame, input logic [63:0] segs, input logic k, input logic m);
    exp_t e;
    e.frame = frame;
    e.segs  = segs;
    e.k     = k;
    e.m     = m;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int         mon_frame = 0;
  bit         in_rst = 1'b0;
  logic [7:0] cap_seg [8];
  int         cap_act [8];
  int         cap_glitch = 0;
  logic       cap_k = 1'b0;
  logic       cap_m = 1'b0;
  int         hit;
  logic [7:0] pat;

  task automatic mon_clear();
    for (int i = 0; i < 8; i++) begin
      cap_seg[i] = 8'hFF;
      cap_act[i] = 0;
    end
    cap_glitch = 0;
  endtask

  task automatic finalize();
    exp_t       e;
    logic [7:0] act_ok;
    while (exp_q.size() > 0 && exp_q[0].frame < mon_frame) begin
      e = exp_q.pop_front();
      check("frame_skipped", 64'(mon_frame), 64'(e.frame));
    end
    if (exp_q.size() > 0 && exp_q[0].frame == mon_frame) begin
      e = exp_q.pop_front();
      for (int i = 7; i >= 0; i--)
        check($sformatf("f%0d_dig%0d_seg", mon_frame, i), 64'(cap_seg[i]), 64'(e.segs[8*i +: 8]));
      for (int i = 0; i < 8; i++) act_ok[i] = (cap_act[i] == SLOT_C - GUARD_C);
      check($sformatf("f%0d_active_cycles_ok", mon_frame), 64'(act_ok), 64'hFF);
      check($sformatf("f%0d_glitches", mon_frame), 64'(cap_glitch), 64'(0));
      check($sformatf("f%0d_led_k", mon_frame), 64'(cap_k), 64'(e.k));
      check($sformatf("f%0d_led_m", mon_frame), 64'(cap_m), 64'(e.m));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rst = 1'b1;
      mon_clear();
    end else begin
      if (in_rst) begin
        in_rst = 1'b0;
        mon_frame++;
      end
      if (frame_done) begin
        finalize();
        mon_clear();
        mon_frame++;
      end
      if (dig_sel != 8'hFF) begin
        hit = -1;
        for (int i = 0; i < 8; i++) begin
          pat = ~(8'd1 << i);
          if (dig_sel == pat) hit = i;
        end
        if (hit < 0) cap_glitch++;
        else begin
          if (cap_act[hit] == 0) cap_seg[hit] = seg;
          else if (seg !== cap_seg[hit]) cap_glitch++;
          cap_act[hit]++;
        end
      end
      cap_k = led_k;
      cap_m = led_m;
    end
  end

  // ---------------- stimulus ----------------
  int stim_frame = 0;
  int pos = 0;       // cycle within the current frame; 0 = frame_done cycle

  task automatic tick();
    @(negedge clk);
    #1;
    if (frame_done) begin
      stim_frame++;
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic next_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (pos != 0 && n < 200);
    if (pos != 0) begin
      total++;
      bad++;
      $display("FAIL frame_wait: no frame_done after %0d cycles", n);
    end
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (pos != p && n < 200) begin
      tick();
      n++;
    end
    if (pos != p) begin
      total++;
      bad++;
      $display("FAIL pos_wait: at %0d, wanted %0d", pos, p);
    end
  endtask

  task automatic pulse(input logic [15:0] fb, input logic [2:0] fp, input logic fk,
                       input logic [15:0] pb, input logic [2:0] pp, input logic pm);
    freq_bcd     = fb;
    freq_point   = fp;
    freq_k       = fk;
    period_bcd   = pb;
    period_point = pp;
    period_m     = pm;
    update       = 1'b1;
    tick();
    update       = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_dig_sel"}, 64'(dig_sel), 64'hFF);
    check({tag, "_seg"}, 64'(seg), 64'hFF);
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_led_k"}, 64'(led_k), 64'(0));
    check({tag, "_led_m"}, 64'(led_m), 64'(0));
  endtask

  initial begin
    // Power-on reset: 3 edges low
    repeat (3) tick();
    reset_check("rst");
    rst_n = 1'b1;
    stim_frame++;
    pos = 0;
    push_exp(stim_frame, RST_PAT, 1'b0, 1'b0);
    tick();
    check("first_slot_cyc1_dig_sel", 64'(dig_sel), 64'hFF);
    tick();
    check("first_slot_cyc2_dig_sel", 64'(dig_sel), 64'h7F);
    check("first_slot_cyc2_seg", 64'(seg), 64'hFF);

    // 0123 p0 / 5000 p3
    push_exp(stim_frame + 1, 64'hFFF9A4B0_12C0C0C0, 1'b1, 1'b0);
    pulse(16'h0123, 3'd0, 1'b1, 16'h5000, 3'd3, 1'b0);

    // mid-frame update: current frame keeps old image
    next_frame();
    wait_pos(20);
    push_exp(stim_frame + 1, 64'h90909090_12C0C0C0, 1'b0, 1'b1);
    pulse(16'h9999, 3'd0, 1'b0, 16'h5000, 3'd3, 1'b1);

    // non-BCD nibble shows 'E'; zero period word
    next_frame();
    wait_pos(5);
    push_exp(stim_frame + 1, 64'hFFFF86C0_FFFFFFC0, 1'b1, 1'b0);
    pulse(16'h00A0, 3'd0, 1'b1, 16'h0000, 3'd0, 1'b0);

    // all-zero freq; period 0007 with point 2 keeps "0.07" lit
    next_frame();
    push_exp(stim_frame + 1, 64'hFFFFFFC0_FF40C0F8, 1'b0, 1'b1);
    pulse(16'h0000, 3'd0, 1'b0, 16'h0007, 3'd2, 1'b1);

    // two updates in one frame: last wins; point 5 gives no dp
    next_frame();
    wait_pos(10);
    pulse(16'h1111, 3'd1, 1'b0, 16'h1111, 3'd1, 1'b1);
    wait_pos(30);
    push_exp(stim_frame + 1, 64'h999282F8_FFF940A4, 1'b1, 1'b0);
    pulse(16'h4567, 3'd5, 1'b1, 16'h0102, 3'd1, 1'b0);

    // pending update, then an update exactly on the frame boundary
    next_frame();
    wait_pos(20);
    pulse(16'h2222, 3'd0, 1'b1, 16'h2222, 3'd0, 1'b0);
    wait_pos(SLOT_C * 8 - 1);
    push_exp(stim_frame + 1, 64'hFF80C0C0_F9A4B099, 1'b0, 1'b1);
    push_exp(stim_frame + 2, 64'hFF80C0C0_F9A4B099, 1'b0, 1'b1);
    pulse(16'h0800, 3'd4, 1'b0, 16'h1234, 3'd0, 1'b1);
    next_frame();
    next_frame();

    // reset mid-slot with an update pending: everything returns to the cleared image
    wait_pos(10);
    pulse(16'h9999, 3'd1, 1'b1, 16'h9999, 3'd1, 1'b1);
    wait_pos(20);
    rst_n = 1'b0;
    tick();
    reset_check("mid_rst");
    rst_n = 1'b1;
    stim_frame++;
    pos = 0;
    push_exp(stim_frame, RST_PAT, 1'b0, 1'b0);
    push_exp(stim_frame + 1, RST_PAT, 1'b0, 1'b0);

    begin
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 400) begin
        tick();
        n++;
      end
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
